// File: rtl/wb_commit.sv
// Writeback/commit stage: retires one instruction result per acceptance into a
// 15-entry register file, condition codes and a commit counter, gated by a RUN/HALT/ERR FSM.
module wb_commit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic        cnd,
  input  logic [2:0]  cf_in,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic [3:0]  rd_addr_a,
  input  logic [3:0]  rd_addr_b,
  output logic [63:0] rd_data_a,
  output logic [63:0] rd_data_b,
  output logic [2:0]  cc_out,
  output logic [1:0]  state,
  output logic [31:0] commit_count
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned NREGS  = 15;
  localparam int unsigned CNT_W  = 32;

  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [3:0] RSP     = 4'h4;

  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;
  localparam logic [3:0] I_LAST  = 4'hB;

  localparam logic [2:0] CC_RESET = 3'b001;

  typedef enum logic [1:0] {
    S_RUN  = 2'b00,
    S_HALT = 2'b01,
    S_ERR  = 2'b10
  } run_state_e;

  run_state_e              state_q;
  logic [DATA_W-1:0]       regs [NREGS];
  logic [2:0]              cc_q;
  logic [CNT_W-1:0]        count_q;
  logic                    ready_q;

  logic                    accept;
  logic                    is_halt;
  logic                    is_bad;
  logic [3:0]              dst_e;
  logic [3:0]              dst_m;
  logic                    we_e;
  logic                    we_m;
  logic                    cc_we;

  assign accept = in_valid && (state_q == S_RUN);
  assign is_halt = (icode == I_HALT);
  assign is_bad  = (icode > I_LAST);

  // Destination decode; RNONE means no write on that path.
  always_comb begin
    dst_e = RNONE;
    dst_m = RNONE;
    unique case (icode)
      I_CMOV:                dst_e = cnd ? rB : RNONE;
      I_IRMOV, I_OPQ:        dst_e = rB;
      I_MRMOV:               dst_m = rA;
      I_CALL, I_RET, I_PUSH: dst_e = RSP;
      I_POP: begin
        dst_e = RSP;
        dst_m = rA;
      end
      default: begin
        dst_e = RNONE;
        dst_m = RNONE;
      end
    endcase
  end

  assign we_e  = accept && (dst_e != RNONE);
  assign we_m  = accept && (dst_m != RNONE);
  assign cc_we = accept && (icode == I_OPQ);

  // State, register file, flags and counter; dstM is written last so it wins a collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      ready_q <= 1'b1;
      cc_q    <= CC_RESET;
      count_q <= '0;
      for (int i = 0; i < int'(NREGS); i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (accept) begin
        count_q <= count_q + CNT_W'(1);
        if (is_halt) begin
          state_q <= S_HALT;
          ready_q <= 1'b0;
        end else if (is_bad) begin
          state_q <= S_ERR;
          ready_q <= 1'b0;
        end
      end
      if (cc_we) begin
        cc_q <= cf_in;
      end
      if (we_e) begin
        regs[dst_e] <= valE;
      end
      if (we_m) begin
        regs[dst_m] <= valM;
      end
    end
  end

  // Read ports see pre-write state; address RNONE reads as zero.
  assign rd_data_a = (rd_addr_a == RNONE) ? DATA_W'(0) : regs[rd_addr_a];
  assign rd_data_b = (rd_addr_b == RNONE) ? DATA_W'(0) : regs[rd_addr_b];

  assign in_ready     = ready_q;
  assign cc_out       = cc_q;
  assign state        = state_q;
  assign commit_count = count_q;

endmodule
